// File: rtl/ysyx_220053_fetch_unit.sv
// ysyx_220053_fetch_unit
//   Instruction fetch front end. Requests sequential instruction words from
//   memory, pairs each in-order response with the PC it was issued for, and
//   buffers {pc, instr, err} in a small queue for the decoder. A credit rule
//   (queued + in flight < DEPTH) keeps the queue from overflowing. A redirect
//   flushes buffered state and discards every response still owed to
//   requests issued before it.
//
// Ports
//   clk, rst              : rising-edge clock, async active-high reset
//   req_valid_o/ready_i   : fetch request handshake, req_addr_o = fetch PC
//   rsp_valid_i           : in-order response (always accepted),
//                           rsp_data_i / rsp_err_i = word / access fault
//   out_valid_o/ready_i   : decode handshake, out_pc_o/out_instr_o/out_err_o
//   redirect_valid_i/pc_i : control-flow change to a new fetch address
module ysyx_220053_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [31:0]     rsp_data_i,
    input  logic            rsp_err_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_instr_o,
    output logic            out_err_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            err;
    } iq_ent_t;

    logic [XLEN-1:0]            fpc_q, fpc_d;
    logic [CW-1:0]              infl_q, infl_d;
    logic [CW-1:0]              drop_q, drop_d;
    logic [CW-1:0]              iq_cnt_q, iq_cnt_d;
    logic [PW-1:0]              iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
    logic [PW-1:0]              pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
    iq_ent_t [DEPTH-1:0]        iq_mem_q;
    logic [DEPTH-1:0][XLEN-1:0] pf_mem_q;

    logic [CW:0] occ;
    logic        req_fire, rsp_acc, rsp_keep, iq_push, iq_pop;
    logic        redir_lsb_unused;

    // Redirect targets are word aligned; the low bits are dropped.
    assign redir_lsb_unused = ^redirect_pc_i[1:0];

    always_comb begin
        occ         = {1'b0, iq_cnt_q} + {1'b0, infl_q};
        // Gate on rst directly so the request drops the moment reset rises.
        req_valid_o = ~rst & (occ < (CW+1)'(DEPTH));
        req_addr_o  = fpc_q;
        req_fire    = req_valid_o & req_ready_i;
        // A response with nothing outstanding is spurious and ignored.
        rsp_acc     = rsp_valid_i & (infl_q != '0);
        // Kept only if it belongs to a request issued after the last redirect.
        rsp_keep    = rsp_acc & (drop_q == '0) & ~redirect_valid_i;
        out_valid_o = (iq_cnt_q != '0);
        iq_push     = rsp_keep;
        iq_pop      = out_valid_o & out_ready_i & ~redirect_valid_i;

        out_pc_o    = out_valid_o ? iq_mem_q[iq_rd_q].pc    : '0;
        out_instr_o = out_valid_o ? iq_mem_q[iq_rd_q].instr : '0;
        out_err_o   = out_valid_o ? iq_mem_q[iq_rd_q].err   : 1'b0;

        infl_d = infl_q + CW'(req_fire) - CW'(rsp_acc);

        drop_d = drop_q;
        if (redirect_valid_i) begin
            // Everything still owed after this cycle, including a request
            // firing right now with the old PC, is stale.
            drop_d = infl_d;
        end else if (rsp_acc && drop_q != '0) begin
            drop_d = drop_q - CW'(1);
        end

        fpc_d = fpc_q;
        if (redirect_valid_i) begin
            fpc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fpc_d = fpc_q + XLEN'(4);
        end

        pf_wr_d  = pf_wr_q;
        pf_rd_d  = pf_rd_q;
        iq_wr_d  = iq_wr_q;
        iq_rd_d  = iq_rd_q;
        iq_cnt_d = iq_cnt_q;
        if (redirect_valid_i) begin
            pf_wr_d  = '0;
            pf_rd_d  = '0;
            iq_wr_d  = '0;
            iq_rd_d  = '0;
            iq_cnt_d = '0;
        end else begin
            if (req_fire) pf_wr_d = pf_wr_q + PW'(1);
            if (rsp_keep) pf_rd_d = pf_rd_q + PW'(1);
            if (iq_push)  iq_wr_d = iq_wr_q + PW'(1);
            if (iq_pop)   iq_rd_d = iq_rd_q + PW'(1);
            iq_cnt_d = iq_cnt_q + CW'(iq_push) - CW'(iq_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q    <= RESET_PC;
            infl_q   <= '0;
            drop_q   <= '0;
            iq_cnt_q <= '0;
            iq_wr_q  <= '0;
            iq_rd_q  <= '0;
            pf_wr_q  <= '0;
            pf_rd_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            infl_q   <= infl_d;
            drop_q   <= drop_d;
            iq_cnt_q <= iq_cnt_d;
            iq_wr_q  <= iq_wr_d;
            iq_rd_q  <= iq_rd_d;
            pf_wr_q  <= pf_wr_d;
            pf_rd_q  <= pf_rd_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the pointers
    // and outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (req_fire && !redirect_valid_i) begin
            pf_mem_q[pf_wr_q] <= fpc_q;
        end
        if (iq_push) begin
            iq_mem_q[iq_wr_q] <= '{pc: pf_mem_q[pf_rd_q], instr: rsp_data_i, err: rsp_err_i};
        end
    end

endmodule

// File: tb/tb_ysyx_220053_fetch_unit.sv
// Testbench for ysyx_220053_fetch_unit: directed sequences driven against an
// in-order memory model with a 1-cycle response latency (gateable), and a
// scoreboard monitor that checks every accepted decode handshake against
// hand-listed expected PCs.
module tb_ysyx_220053_fetch_unit;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        out_valid, out_ready, out_err;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_220053_fetch_unit #(.XLEN(64), .RESET_PC(64'h8000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
        .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_err_i(rsp_err),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
        .out_instr_o(out_instr), .out_err_o(out_err),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] pend[$];
    logic [63:0] mem_a;
    logic [63:0] err_addr;
    bit          mem_en;
    int          n_checks, n_pass, n_fires;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    task automatic push(input logic [63:0] pc, input logic err);
        exp_t e;
        e.pc = pc; e.instr = mdata(pc); e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: responses return in order one cycle after the request fires.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            rsp_valid = 1'b0;
        end else begin
            if (mem_en && pend.size() > 0) begin
                mem_a     = pend.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = mdata(mem_a);
                rsp_err   = (mem_a == err_addr);
            end else begin
                rsp_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                pend.push_back(req_addr);
                n_fires++;
            end
        end
    end

    // Scoreboard monitor: a redirect in the same cycle cancels the pop.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out actual_pc=%h expected=none", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_instr", 64'(out_instr), 64'(mon_e.instr));
                chk("out_err", 64'(out_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        clk = 0; rst = 1; req_ready = 0; out_ready = 0;
        redirect_valid = 0; redirect_pc = '0;
        rsp_valid = 0; rsp_data = '0; rsp_err = 0;
        mem_en = 1; err_addr = '0; n_checks = 0; n_pass = 0; n_fires = 0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);

        // Streaming, one instruction per cycle
        req_ready = 1; out_ready = 1;
        for (int i = 0; i < 6; i++) push(RPC + 64'(4*i), 1'b0);
        rst = 0;
        #1;
        chk("first_req_valid", 64'(req_valid), 64'd1);
        chk("first_req_addr", req_addr, RPC);
        repeat (3) @(negedge clk); #1;
        for (int c = 2; c <= 4; c++) begin
            chk("b2b_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req_ready = 0;
        drain("t2_drain");

        // Decode stalled: credits stop fetch at DEPTH
        @(posedge clk); #1;
        rst = 1; out_ready = 0; req_ready = 1; n_fires = 0;
        for (int i = 0; i < 4; i++) push(RPC + 64'(4*i), 1'b0);
        @(posedge clk); #1;
        rst = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        chk("stall_fires", 64'(n_fires), 64'd4);
        chk("stall_req_valid", 64'(req_valid), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_pc", out_pc, RPC);
        @(posedge clk); #1;
        out_ready = 1; req_ready = 0;
        drain("t3_drain");
        @(negedge clk); #1;
        chk("resume_req_valid", 64'(req_valid), 64'd1);
        chk("resume_req_addr", req_addr, RPC + 64'd16);

        // Redirect with 3 requests in flight
        @(posedge clk); #1;
        mem_en = 0; req_ready = 1;
        repeat (3) @(posedge clk); #1;
        req_ready = 0;
        chk("t4_fires", 64'(n_fires), 64'd7);
        redirect_valid = 1; redirect_pc = 64'h8000_1002;
        @(posedge clk); #1;
        redirect_valid = 0;
        chk("redir_req_addr", req_addr, 64'h8000_1000);
        chk("redir_out_valid", 64'(out_valid), 64'd0);
        mem_en = 1;
        repeat (6) @(posedge clk); #1;
        chk("redir_discard_out_valid", 64'(out_valid), 64'd0);
        push(64'h8000_1000, 1'b0); push(64'h8000_1004, 1'b0); push(64'h8000_1008, 1'b0);
        req_ready = 1;
        repeat (3) @(posedge clk); #1;
        req_ready = 0;
        drain("t4_drain");

        // Redirect coincident with a request fire and a response
        @(posedge clk); #1;
        req_ready = 1;
        @(posedge clk); #1;
        redirect_valid = 1; redirect_pc = 64'h8000_2000;
        @(negedge clk); #1;
        chk("coincide_fire_rsp", 64'(req_valid & req_ready & rsp_valid), 64'd1);
        push(64'h8000_2000, 1'b0); push(64'h8000_2004, 1'b0);
        @(posedge clk); #1;
        redirect_valid = 0;
        chk("coincide_req_addr", req_addr, 64'h8000_2000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_ready = 0;
        drain("t5_drain");

        // Access fault on the second response
        @(posedge clk); #1;
        rst = 1; err_addr = 64'h8000_0004; req_ready = 1; out_ready = 1;
        push(RPC, 1'b0); push(RPC + 64'd4, 1'b1); push(RPC + 64'd8, 1'b0);
        push(RPC + 64'd12, 1'b0); push(RPC + 64'd16, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        repeat (5) @(posedge clk); #1;
        req_ready = 0;
        drain("t6_drain");

        // Asynchronous reset pulse mid-stream
        err_addr = '0;
        @(posedge clk); #1;
        req_ready = 1;
        push(64'h8000_0014, 1'b0); push(64'h8000_0018, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst = 1;
        #1;
        chk("async_rst_req_valid", 64'(req_valid), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("pre_rst_delivered", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) push(RPC + 64'(4*i), 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("refetch_req_valid", 64'(req_valid), 64'd1);
        chk("refetch_req_addr", req_addr, RPC);
        repeat (3) @(posedge clk); #1;
        req_ready = 0;
        drain("t7_drain");

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
